// File: rtl/win_fetch_sched_if.sv
// Bus between the window-fetch scheduler, the top control FSM, the padded-image BRAM
// and the histogram unit.
interface win_fetch_sched_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic              hold;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              win_valid;
    logic              win_first;
    logic              win_last;
    logic              wf;
    logic              busy;
    logic [14:0]       pix_cnt;
    logic              all_done;

    modport master (
        input  start,
        input  hold,
        output rd_en,
        output rd_addr,
        output win_valid,
        output win_first,
        output win_last,
        output wf,
        output busy,
        output pix_cnt,
        output all_done
    );

    modport slave (
        output start,
        output hold,
        input  rd_en,
        input  rd_addr,
        input  win_valid,
        input  win_first,
        input  win_last,
        input  wf,
        input  busy,
        input  pix_cnt,
        input  all_done
    );
endinterface

// File: rtl/win_fetch_sched.sv
// Window-fetch address scheduler: walks the output raster and, per start pulse, reads the
// WIN x WIN neighbourhood from the padded image BRAM in row-major order.
module win_fetch_sched #(
    parameter int IMG_W  = 150,
    parameter int IMG_H  = 150,
    parameter int WIN    = 15,
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              re,
    win_fetch_sched_if.master bus
);
    localparam int PW   = IMG_W + WIN - 1;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int WW   = $clog2(WIN + 1);
    localparam int DW   = $clog2(RD_LAT + 1);

    localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1);
    localparam logic [WW-1:0]     WIN_LAST   = WW'(WIN - 1);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT - 1);
    localparam logic [14:0]       PIX_LAST   = 15'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(PW - WIN + 1);
    localparam logic [ADDR_W-1:0] WRAP_STEP  = ADDR_W'(WIN);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        ACK
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     col;
    logic [WW-1:0]     wr;
    logic [WW-1:0]     wc;
    logic [DW-1:0]     drain_cnt;
    logic [14:0]       pix_cnt_q;
    logic              done_q;

    logic [RD_LAT-1:0] v_pipe;
    logic [RD_LAT-1:0] f_pipe;
    logic [RD_LAT-1:0] l_pipe;

    logic              launch;
    logic              issue;
    logic              issue_first;
    logic              issue_last;
    logic              final_ack;

    always_comb begin
        launch      = (state == IDLE) && bus.start && !done_q;
        issue       = (state == FETCH) && !bus.hold;
        issue_first = issue && (wr == '0) && (wc == '0);
        issue_last  = issue && (wr == WIN_LAST) && (wc == WIN_LAST);
        final_ack   = (state == ACK) && (pix_cnt_q == PIX_LAST);
    end

    always_ff @(posedge clk) begin
        if (re) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = FETCH;
            FETCH:   if (issue_last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window address is stepped incrementally: +1 along a window row, then jump to the
    // start of the next window row in the padded image.
    always_ff @(posedge clk) begin
        if (re) begin
            addr <= '0;
            wr   <= '0;
            wc   <= '0;
        end else if (launch) begin
            addr <= base;
            wr   <= '0;
            wc   <= '0;
        end else if (issue) begin
            if (wc == WIN_LAST) begin
                wc   <= '0;
                wr   <= wr + 1'b1;
                addr <= addr + ROW_STEP;
            end else begin
                wc   <= wc + 1'b1;
                addr <= addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // The last output column moves base onto the next padded row: (r*PW + IMG_W-1) + WIN = (r+1)*PW.
    always_ff @(posedge clk) begin
        if (re) begin
            base      <= '0;
            col       <= '0;
            pix_cnt_q <= '0;
            done_q    <= 1'b0;
        end else if (state == ACK) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_cnt_q == PIX_LAST) begin
                done_q <= 1'b1;
            end
            if (col == COL_LAST) begin
                col  <= '0;
                base <= base + WRAP_STEP;
            end else begin
                col  <= col + 1'b1;
                base <= base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            v_pipe <= '0;
            f_pipe <= '0;
            l_pipe <= '0;
        end else begin
            v_pipe[0] <= issue;
            f_pipe[0] <= issue_first;
            l_pipe[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                f_pipe[i] <= f_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
            end
        end
    end

    // all_done must rise together with the final wf, so it is not purely registered.
    assign bus.rd_en     = issue;
    assign bus.rd_addr   = addr;
    assign bus.win_valid = v_pipe[RD_LAT-1];
    assign bus.win_first = f_pipe[RD_LAT-1];
    assign bus.win_last  = l_pipe[RD_LAT-1];
    assign bus.wf        = (state == ACK);
    assign bus.busy      = (state != IDLE);
    assign bus.pix_cnt   = pix_cnt_q;
    assign bus.all_done  = done_q || final_ack;
endmodule

// File: tb/tb_win_fetch_sched.sv
// Scoreboard bench: a default-size scheduler for address sequence and timing, plus a small
// instance (5x4 image, WIN=3, RD_LAT=2) that is run through a whole frame.
module tb_win_fetch_sched;
    localparam int N_W   [2] = '{150, 5};
    localparam int N_H   [2] = '{150, 4};
    localparam int N_WIN [2] = '{15, 3};
    localparam int N_LAT [2] = '{1, 2};

    typedef struct packed {
        logic [31:0] addr;
        logic        first;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic re_a;
    logic re_b;

    always #5 clk = ~clk;

    win_fetch_sched_if #(.ADDR_W(15)) bus_a ();
    win_fetch_sched_if #(.ADDR_W(8))  bus_b ();

    win_fetch_sched #(
        .IMG_W(150), .IMG_H(150), .WIN(15), .ADDR_W(15), .RD_LAT(1)
    ) u_dut_a (
        .clk(clk),
        .re (re_a),
        .bus(bus_a)
    );

    win_fetch_sched #(
        .IMG_W(5), .IMG_H(4), .WIN(3), .ADDR_W(8), .RD_LAT(2)
    ) u_dut_b (
        .clk(clk),
        .re (re_b),
        .bus(bus_b)
    );

    beat_t exp_rd  [2][$];
    beat_t exp_dat [2][$];
    int    exp_wf  [2][$];

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int first_addr [2];
    int last_addr  [2];
    int done_cnt   [2];

    int bram_a;
    int bram_b [2];

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM stand-in: the returned word is the address that was presented RD_LAT edges earlier.
    always @(posedge clk) begin
        bram_a    <= int'(bus_a.rd_addr);
        bram_b[0] <= int'(bus_b.rd_addr);
        bram_b[1] <= bram_b[0];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic observe(input int i, input logic rst, input logic rd_en, input int rd_addr,
                           input logic v, input logic f, input logic l, input int data,
                           input logic wf, input logic all_done);
        beat_t b;
        if (rst !== 1'b0) return;
        if (rd_en === 1'b1) begin
            last_addr[i] = rd_addr;
            checkOutput($sformatf("u%0d read_expected", i), int'(exp_rd[i].size() > 0), 1);
            if (exp_rd[i].size() > 0) begin
                b = exp_rd[i].pop_front();
                if (b.first) first_addr[i] = rd_addr;
                checkOutput($sformatf("u%0d rd_addr", i), rd_addr, b.addr);
            end
        end
        if (v === 1'b1) begin
            checkOutput($sformatf("u%0d valid_expected", i), int'(exp_dat[i].size() > 0), 1);
            if (exp_dat[i].size() > 0) begin
                b = exp_dat[i].pop_front();
                checkOutput($sformatf("u%0d win_data", i), data, b.addr);
                checkOutput($sformatf("u%0d win_first", i), f, b.first);
                checkOutput($sformatf("u%0d win_last", i), l, b.last);
            end
        end
        if (wf === 1'b1) begin
            checkOutput($sformatf("u%0d wf_expected", i), int'(exp_wf[i].size() > 0), 1);
            if (exp_wf[i].size() > 0) begin
                checkOutput($sformatf("u%0d wf_cycle", i), cyc + 1, exp_wf[i].pop_front());
            end
            checkOutput($sformatf("u%0d all_done_at_wf", i), all_done,
                        int'(done_cnt[i] + 1 == N_W[i] * N_H[i]));
            done_cnt[i]++;
        end
    endtask

    always @(negedge clk) begin
        observe(0, re_a, bus_a.rd_en, int'(bus_a.rd_addr), bus_a.win_valid, bus_a.win_first,
                bus_a.win_last, bram_a, bus_a.wf, bus_a.all_done);
        observe(1, re_b, bus_b.rd_en, int'(bus_b.rd_addr), bus_b.win_valid, bus_b.win_first,
                bus_b.win_last, bram_b[1], bus_b.wf, bus_b.all_done);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic rst, input logic st, input logic hd);
        if (i == 0) begin
            re_a = rst; bus_a.start = st; bus_a.hold = hd;
        end else begin
            re_b = rst; bus_b.start = st; bus_b.hold = hd;
        end
    endtask

    task automatic flushScoreboard(input int i);
        exp_rd[i].delete();
        exp_dat[i].delete();
        exp_wf[i].delete();
        done_cnt[i] = 0;
    endtask

    task automatic resetDut(input int i, input int n);
        drive(i, 1'b1, 1'b0, 1'b0);
        tick(n);
        drive(i, 1'b0, 1'b0, 1'b0);
        flushScoreboard(i);
    endtask

    // Pushes the expected window of pixel p, then pulses start; returns after the start edge t.
    task automatic startWindow(input int i, input int p, input int hold_after, input int hold_len,
                               output int t);
        int    pw;
        int    base;
        beat_t b;
        pw   = N_W[i] + N_WIN[i] - 1;
        base = (p / N_W[i]) * pw + (p % N_W[i]);
        t    = cyc + 1;
        for (int wr = 0; wr < N_WIN[i]; wr++) begin
            for (int wc = 0; wc < N_WIN[i]; wc++) begin
                b.addr  = base + wr * pw + wc;
                b.first = (wr == 0) && (wc == 0);
                b.last  = (wr == N_WIN[i] - 1) && (wc == N_WIN[i] - 1);
                exp_rd[i].push_back(b);
                exp_dat[i].push_back(b);
            end
        end
        exp_wf[i].push_back(t + N_WIN[i] * N_WIN[i] + N_LAT[i] + 1 + hold_len);
        drive(i, 1'b0, 1'b1, 1'b0);
        tick(1);
        drive(i, 1'b0, 1'b0, 1'b0);
        if (hold_len > 0) begin
            tick(hold_after);
            drive(i, 1'b0, 1'b0, 1'b1);
            tick(hold_len);
            drive(i, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic waitWindow(input int i);
        for (int k = 0; k < 1000 && exp_wf[i].size() != 0; k++) tick(1);
        checkOutput($sformatf("u%0d window_complete", i), exp_wf[i].size(), 0);
        checkOutput($sformatf("u%0d reads_drained", i), exp_rd[i].size(), 0);
        checkOutput($sformatf("u%0d data_drained", i), exp_dat[i].size(), 0);
        tick(1);
    endtask

    task automatic applyStimulus(input int i, input int p, input int hold_after, input int hold_len,
                                 input bit stray_start);
        int t;
        startWindow(i, p, hold_after, hold_len, t);
        if (stray_start) begin
            tick(49);
            drive(i, 1'b0, 1'b1, 1'b0);
            tick(1);
            drive(i, 1'b0, 1'b0, 1'b0);
        end
        waitWindow(i);
    endtask

    task automatic seqA();
        int t;
        resetDut(0, 3);
        checkOutput("a reset rd_en", bus_a.rd_en, 0);
        checkOutput("a reset rd_addr", bus_a.rd_addr, 0);
        checkOutput("a reset busy", bus_a.busy, 0);
        checkOutput("a reset wf", bus_a.wf, 0);
        checkOutput("a reset win_valid", bus_a.win_valid, 0);
        checkOutput("a reset pix_cnt", bus_a.pix_cnt, 0);
        checkOutput("a reset all_done", bus_a.all_done, 0);
        tick(5);

        applyStimulus(0, 0, 0, 0, 1'b0);
        checkOutput("a p0 first_addr", first_addr[0], 0);
        checkOutput("a p0 last_addr", last_addr[0], 2310);
        checkOutput("a p0 pix_cnt", bus_a.pix_cnt, 1);

        applyStimulus(0, 1, 0, 0, 1'b1);
        checkOutput("a p1 first_addr", first_addr[0], 1);
        checkOutput("a p1 last_addr", last_addr[0], 2311);

        applyStimulus(0, 2, 20, 5, 1'b0);
        checkOutput("a p2 last_addr", last_addr[0], 2312);
        checkOutput("a p2 pix_cnt", bus_a.pix_cnt, 3);

        for (int p = 3; p <= 150; p++) begin
            applyStimulus(0, p, 0, 0, 1'b0);
            if (p == 149) checkOutput("a p149 first_addr", first_addr[0], 149);
        end
        checkOutput("a p150 first_addr", first_addr[0], 164);
        checkOutput("a p150 last_addr", last_addr[0], 2474);
        checkOutput("a pix_cnt 151", bus_a.pix_cnt, 151);
        checkOutput("a all_done low", bus_a.all_done, 0);

        // Reset lands on the edge after the 100th read of pixel 151 (base 165).
        startWindow(0, 151, 0, 0, t);
        tick(100);
        drive(0, 1'b1, 1'b0, 1'b0);
        tick(1);
        drive(0, 1'b0, 1'b0, 1'b0);
        flushScoreboard(0);
        checkOutput("a midreset last_addr", last_addr[0], 1158);
        checkOutput("a midreset rd_en", bus_a.rd_en, 0);
        checkOutput("a midreset win_valid", bus_a.win_valid, 0);
        checkOutput("a midreset busy", bus_a.busy, 0);
        checkOutput("a midreset pix_cnt", bus_a.pix_cnt, 0);

        tick(2);
        drive(0, 1'b1, 1'b1, 1'b0);
        tick(1);
        drive(0, 1'b0, 1'b0, 1'b0);
        checkOutput("a start_with_re busy", bus_a.busy, 0);
        tick(5);
        checkOutput("a start_with_re idle", bus_a.busy, 0);

        applyStimulus(0, 0, 0, 0, 1'b0);
        checkOutput("a restart first_addr", first_addr[0], 0);
        checkOutput("a restart last_addr", last_addr[0], 2310);
        checkOutput("a restart pix_cnt", bus_a.pix_cnt, 1);
    endtask

    task automatic seqB();
        resetDut(1, 3);
        checkOutput("b reset pix_cnt", bus_b.pix_cnt, 0);
        checkOutput("b reset all_done", bus_b.all_done, 0);
        tick(3);
        for (int p = 0; p < 20; p++) begin
            applyStimulus(1, p, 0, 0, 1'b0);
        end
        checkOutput("b final first_addr", first_addr[1], 25);
        checkOutput("b final last_addr", last_addr[1], 41);
        checkOutput("b final pix_cnt", bus_b.pix_cnt, 20);
        checkOutput("b final all_done", bus_b.all_done, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b0, 1'b1, 1'b0);
            tick(1);
            drive(1, 1'b0, 1'b0, 1'b0);
            tick(3);
        end
        checkOutput("b after_done busy", bus_b.busy, 0);
        checkOutput("b after_done pix_cnt", bus_b.pix_cnt, 20);
        checkOutput("b after_done all_done", bus_b.all_done, 1);
    endtask

    initial begin
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0);
        fork
            seqA();
            seqB();
        join
        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
